mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter word_size, default 8, sets the data and address width.
REQ-002 Parameter cpu_quantum, default 8, sets the max CPU ownership cycles while the loader waits.
REQ-003 Parameter ldr_quantum, default 4, sets the max loader ownership cycles while the CPU waits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req  input  1  processor requests the memory port this cycle.
REQ-007 cpu_write  input  1  processor access is a write.
REQ-008 cpu_addr  input  word_size  processor address.
REQ-009 cpu_wdata  input  word_size  processor write data (Bus_1).
REQ-010 ldr_req  input  1  loader/DMA requests the memory port.
REQ-011 ldr_write  input  1  loader access is a write.
REQ-012 ldr_addr  input  word_size  loader address.
REQ-013 ldr_wdata  input  word_size  loader write data.
REQ-014 ldr_last  input  1  current loader beat is the final beat of its burst.
REQ-015 cpu_gnt  output  1  processor owns the port (registered).
REQ-016 ldr_gnt  output  1  loader owns the port (registered).
REQ-017 cpu_stall  output  1  equals cpu_req AND NOT cpu_gnt; freezes the controller sequencing.
REQ-018 mem_address  output  word_size  to the Memory_Unit address input.
REQ-019 mem_data_in  output  word_size  to the Memory_Unit data_in.
REQ-020 mem_write  output  1  to the Memory_Unit write strobe.

Function
REQ-021 FSM states SHALL be IDLE, CPU_OWN and LDR_OWN; cpu_gnt=1 only in CPU_OWN and ldr_gnt=1 only in LDR_OWN.
REQ-022 IDLE: cpu_req only -> CPU_OWN; ldr_req only -> LDR_OWN; both asserted -> the requester other than last_served; neither -> stay in IDLE.
REQ-023 last_served SHALL be a 1-bit register updated to the owner on each entry into CPU_OWN/LDR_OWN; its reset value is LOADER, so the CPU wins the first tie.
REQ-024 Grant latency SHALL be one cycle: a request first seen at edge N gives a grant visible after edge N.
REQ-025 CPU_OWN exit: cpu_req=0 -> LDR_OWN if ldr_req else IDLE; cpu_req=1, ldr_req=1 and beat_cnt = cpu_quantum-1 -> LDR_OWN; otherwise stay.
REQ-026 LDR_OWN exit: ldr_req=0, or ldr_req=1 with ldr_last=1 -> CPU_OWN if cpu_req else IDLE; ldr_req=1, cpu_req=1 and beat_cnt = ldr_quantum-1 -> CPU_OWN; otherwise stay.
REQ-027 The direct owner-to-owner handover SHALL NOT pass through IDLE (no bubble cycle).
REQ-028 beat_cnt SHALL be 4 bits wide, clear to 0 on every state change, increment each cycle in an owner state, and saturate at 15.
REQ-029 With no competing request, an owner SHALL keep the port indefinitely; the quantum applies only while the other side requests.
REQ-030 Output mux (combinational from state): CPU_OWN -> cpu_addr/cpu_wdata, mem_write = cpu_write AND cpu_req; LDR_OWN -> ldr_* fields, mem_write = ldr_write AND ldr_req; IDLE -> all zeros.
REQ-031 mem_write SHALL never be 1 for a requester without its grant; a write issued in the grant-arrival cycle is committed in that same cycle.
REQ-032 The final loader beat (ldr_last=1) SHALL still be driven to the memory in its cycle; the handover takes effect at the next edge.
REQ-033 Read data SHALL NOT pass through this block; mem_word goes to both requesters, and each requester qualifies it with its own gnt.

Reset
REQ-034 On rst=0, asynchronously: state=IDLE, beat_cnt=0, last_served=LOADER, cpu_gnt=0, ldr_gnt=0, mem_address=0, mem_data_in=0, mem_write=0.
REQ-035 Reset asserted mid-burst SHALL drop mem_write in the same cycle, and the interrupted burst is not resumed.
REQ-036 The first grant SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-037 Reset release, cpu_req=1, ldr_req=1 in the same cycle -> cpu_gnt=1 after edge 1, ldr_gnt=0, cpu_stall=0.
REQ-038 CPU holds cpu_req=1 with ldr_req=1 and cpu_quantum=8 -> ldr_gnt=1 exactly 8 cycles after cpu_gnt rose; no IDLE cycle in between.
REQ-039 Loader burst of writes to addresses 0x10..0x12, ldr_last on the 3rd beat, cpu_req=0 -> memory holds the 3 words, then state=IDLE and mem_write=0.
REQ-040 Loader owns the port, cpu_req rises, ldr_quantum=4, burst of 10 beats -> CPU granted after 4 loader beats; cpu_stall=1 during the wait; loader resumes at its next turn.
REQ-041 rst pulsed low during a loader write (ldr_addr=0x20) -> mem_write=0 and ldr_gnt=0 within the same cycle, with no write at the following edge.
REQ-042 Only ldr_req asserted from IDLE, then cpu_req -> tie-break test: after the loader releases, a simultaneous request from IDLE goes to the CPU.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between the processor and a loader/DMA engine.
// Alternates on ties, bounds each owner's tenure while the other side waits, and hands over without an idle bubble.
module mem_port_arbiter #(
    parameter int word_size   = 8,
    parameter int cpu_quantum = 8,
    parameter int ldr_quantum = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_write,
    input  logic [word_size-1:0] cpu_addr,
    input  logic [word_size-1:0] cpu_wdata,
    input  logic                 ldr_req,
    input  logic                 ldr_write,
    input  logic [word_size-1:0] ldr_addr,
    input  logic [word_size-1:0] ldr_wdata,
    input  logic                 ldr_last,
    output logic                 cpu_gnt,
    output logic                 ldr_gnt,
    output logic                 cpu_stall,
    output logic [word_size-1:0] mem_address,
    output logic [word_size-1:0] mem_data_in,
    output logic                 mem_write
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        LDR_OWN = 2'd2
    } state_t;

    localparam logic       SERVED_CPU    = 1'b0;
    localparam logic       SERVED_LOADER = 1'b1;
    localparam logic [3:0] CPU_LAST_BEAT = 4'(cpu_quantum - 1);
    localparam logic [3:0] LDR_LAST_BEAT = 4'(ldr_quantum - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] beat_cnt;
    logic       last_served;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat_cnt    <= 4'd0;
            last_served <= SERVED_LOADER;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                beat_cnt <= 4'd0;
                if (state_next == CPU_OWN)
                    last_served <= SERVED_CPU;
                else if (state_next == LDR_OWN)
                    last_served <= SERVED_LOADER;
            end else if (state != IDLE && beat_cnt != 4'd15) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

    // Quantum only forces a handover while the other side is actually waiting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req && ldr_req)
                    state_next = (last_served == SERVED_LOADER) ? CPU_OWN : LDR_OWN;
                else if (cpu_req)
                    state_next = CPU_OWN;
                else if (ldr_req)
                    state_next = LDR_OWN;
            end
            CPU_OWN: begin
                if (!cpu_req)
                    state_next = ldr_req ? LDR_OWN : IDLE;
                else if (ldr_req && beat_cnt == CPU_LAST_BEAT)
                    state_next = LDR_OWN;
            end
            LDR_OWN: begin
                if (!ldr_req || ldr_last)
                    state_next = cpu_req ? CPU_OWN : IDLE;
                else if (cpu_req && beat_cnt == LDR_LAST_BEAT)
                    state_next = CPU_OWN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobe is gated by the owner's own request so a granted-but-idle side never writes.
    always_comb begin
        cpu_gnt     = 1'b0;
        ldr_gnt     = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        mem_write   = 1'b0;
        case (state)
            CPU_OWN: begin
                cpu_gnt     = 1'b1;
                mem_address = cpu_addr;
                mem_data_in = cpu_wdata;
                mem_write   = cpu_write & cpu_req;
            end
            LDR_OWN: begin
                ldr_gnt     = 1'b1;
                mem_address = ldr_addr;
                mem_data_in = ldr_wdata;
                mem_write   = ldr_write & ldr_req;
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an ownership-level reference model checked every cycle,
// plus literal expectations for the tie-break, quantum, burst, and reset scenarios.
module tb_mem_port_arbiter;

    localparam int CPU_Q = 8;
    localparam int LDR_Q = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_req = 1'b0, cpu_write = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
    logic       ldr_req = 1'b0, ldr_write = 1'b0, ldr_last = 1'b0;
    logic [7:0] ldr_addr = 8'h00, ldr_wdata = 8'h00;
    logic       cpu_gnt, ldr_gnt, cpu_stall, mem_write;
    logic [7:0] mem_address, mem_data_in;

    always #5 clk = ~clk;

    mem_port_arbiter #(.word_size(8), .cpu_quantum(CPU_Q), .ldr_quantum(LDR_Q)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ldr_req(ldr_req), .ldr_write(ldr_write), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_last(ldr_last),
        .cpu_gnt(cpu_gnt), .ldr_gnt(ldr_gnt), .cpu_stall(cpu_stall),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write)
    );

    // Memory the port drives, plus a per-address write count.
    logic [7:0] dmem [256];
    int         wcnt [256];
    initial for (int i = 0; i < 256; i++) begin dmem[i] = 8'h00; wcnt[i] = 0; end
    always @(posedge clk) if (mem_write) begin
        dmem[mem_address] <= mem_data_in;
        wcnt[mem_address] <= wcnt[mem_address] + 1;
    end

    // Reference model: who owns the port (0 none, 1 cpu, 2 loader), how long, and who won last.
    int m_owner = 0, m_held = 0, m_prev = 2, m_nxt;
    always_comb begin
        m_nxt = m_owner;
        if (m_owner == 0) begin
            if (cpu_req && ldr_req) m_nxt = (m_prev == 1) ? 2 : 1;
            else if (cpu_req)       m_nxt = 1;
            else if (ldr_req)       m_nxt = 2;
        end else if (m_owner == 1) begin
            if (!cpu_req)                              m_nxt = ldr_req ? 2 : 0;
            else if (ldr_req && m_held + 1 == CPU_Q)   m_nxt = 2;
        end else begin
            if (!ldr_req || ldr_last)                  m_nxt = cpu_req ? 1 : 0;
            else if (cpu_req && m_held + 1 == LDR_Q)   m_nxt = 1;
        end
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= 0; m_held <= 0; m_prev <= 2;
        end else begin
            m_owner <= m_nxt;
            if (m_nxt != m_owner) begin
                m_held <= 0;
                if (m_nxt != 0) m_prev <= m_nxt;
            end else if (m_owner != 0) begin
                m_held <= (m_held < 15) ? m_held + 1 : 15;
            end
        end
    end

    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } lit_t;
    lit_t lit_q [$];
    int tests = 0, fails = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e_addr, e_data;
        logic       e_wr;
        lit_t       l;
        e_addr = 8'h00; e_data = 8'h00; e_wr = 1'b0;
        if (m_owner == 1) begin e_addr = cpu_addr; e_data = cpu_wdata; e_wr = cpu_write & cpu_req; end
        if (m_owner == 2) begin e_addr = ldr_addr; e_data = ldr_wdata; e_wr = ldr_write & ldr_req; end
        chk("cpu_gnt",     32'(cpu_gnt),     32'(m_owner == 1));
        chk("ldr_gnt",     32'(ldr_gnt),     32'(m_owner == 2));
        chk("cpu_stall",   32'(cpu_stall),   32'(cpu_req && m_owner != 1));
        chk("mem_write",   32'(mem_write),   32'(e_wr));
        chk("mem_address", 32'(mem_address), 32'(e_addr));
        chk("mem_data_in", 32'(mem_data_in), 32'(e_data));
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            chk(l.name, l.act, l.exp);
        end
    end

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_q.push_back('{n, a, e});
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Loader burst of n write beats from base; optionally the CPU requests once cpu_at
    // loader beats have committed and releases after cpu_hold granted cycles.
    task automatic ldr_burst(input logic [7:0] base, input int n, input int cpu_at,
                             input int cpu_hold, output int beats_before_cpu);
        int idx = 0, have = 0, cyc = 0;
        logic g, cg;
        beats_before_cpu = -1;
        ldr_req = 1'b1; ldr_write = 1'b1; ldr_addr = base; ldr_wdata = 8'hC0; ldr_last = (n == 1);
        while ((idx < n || cpu_req) && cyc < 200) begin
            #1; g = ldr_gnt; cg = cpu_gnt;
            if (cg && beats_before_cpu < 0) beats_before_cpu = idx;
            tick(); cyc++;
            if (g)  idx++;
            if (cg) have++;
            if (cpu_hold > 0 && have == 0 && idx == cpu_at) cpu_req = 1'b1;
            if (cpu_hold > 0 && have >= cpu_hold) cpu_req = 1'b0;
            cpu_write = 1'b1; cpu_addr = 8'h80 + 8'(have); cpu_wdata = 8'h50 + 8'(have);
            if (idx < n) begin
                ldr_addr = base + 8'(idx); ldr_wdata = 8'hC0 + 8'(idx); ldr_last = (idx == n - 1);
            end else begin
                ldr_req = 1'b0; ldr_write = 1'b0; ldr_last = 1'b0;
            end
        end
        if (cyc >= 200) lit("burst_timeout", 32'd0, 32'd1);
    endtask

    int k, bubble, bb;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        lit("reset_outputs", {12'd0, cpu_gnt, ldr_gnt, cpu_stall, mem_write, mem_address, mem_data_in}, 32'd0);

        // Release with both requesting: CPU wins the first tie.
        rst = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1; cpu_addr = 8'h05; ldr_addr = 8'h40;
        tick(); #1;
        lit("tie1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        lit("tie1_ldr_gnt", 32'(ldr_gnt), 32'd0);
        lit("tie1_stall",   32'(cpu_stall), 32'd0);

        k = 0; bubble = 0;
        while (!ldr_gnt && k < 20) begin
            tick(); k++; #1;
            if (!cpu_gnt && !ldr_gnt) bubble = 1;
        end
        lit("cpu_quantum_cycles", 32'(k), 32'd8);
        lit("cpu_to_ldr_bubble", 32'(bubble), 32'd0);

        k = 0;
        while (!cpu_gnt && k < 20) begin
            tick(); k++; #1;
            if (!cpu_gnt && !ldr_gnt) bubble = 1;
        end
        lit("ldr_quantum_cycles", 32'(k), 32'd4);
        lit("ldr_to_cpu_bubble", 32'(bubble), 32'd0);

        // CPU was served last, so the next tie from IDLE goes to the loader.
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick(); #1;
        lit("idle_after_release", {30'd0, cpu_gnt, ldr_gnt}, 32'd0);
        cpu_req = 1'b1; ldr_req = 1'b1;
        tick(); #1;
        lit("tie2_ldr_gnt", 32'(ldr_gnt), 32'd1);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick(); tick();

        // Three-beat loader write burst ending in IDLE.
        ldr_burst(8'h10, 3, -1, 0, bb);
        #1;
        lit("burst3_mem10", 32'(dmem[8'h10]), 32'hC0);
        lit("burst3_mem11", 32'(dmem[8'h11]), 32'hC1);
        lit("burst3_mem12", 32'(dmem[8'h12]), 32'hC2);
        lit("burst3_idle",  {30'd0, ldr_gnt, mem_write}, 32'd0);
        tick(); tick();

        // Ten-beat burst preempted by the CPU after the loader quantum, then resumed.
        ldr_burst(8'h30, 10, 1, 2, bb);
        #1;
        lit("preempt_beats", 32'(bb), 32'd4);
        lit("preempt_mem33", 32'(dmem[8'h33]), 32'hC3);
        lit("preempt_mem34", 32'(dmem[8'h34]), 32'hC4);
        lit("preempt_mem39", 32'(dmem[8'h39]), 32'hC9);
        lit("preempt_cpu80", 32'(dmem[8'h80]), 32'h50);
        lit("preempt_cpu81", 32'(dmem[8'h81]), 32'h51);
        tick(); tick();

        // Reset pulse during a granted loader write to 0x20.
        ldr_req = 1'b1; ldr_write = 1'b1; ldr_addr = 8'h20; ldr_wdata = 8'h77; ldr_last = 1'b0;
        tick(); #1;
        lit("pre_reset_write", 32'(mem_write), 32'd1);
        #1 rst = 1'b0;
        #1;
        lit("reset_drops_write", 32'(mem_write), 32'd0);
        lit("reset_drops_gnt",   32'(ldr_gnt),   32'd0);
        tick(); #1;
        lit("no_write_0x20", 32'(wcnt[8'h20]), 32'd0);
        ldr_req = 1'b0; ldr_write = 1'b0;
        #1 rst = 1'b1;
        tick(); #1;
        lit("burst_not_resumed", 32'(ldr_gnt), 32'd0);

        // Loader alone, then release, then a tie goes to the CPU.
        ldr_req = 1'b1;
        tick(); #1;
        lit("ldr_alone_gnt", 32'(ldr_gnt), 32'd1);
        ldr_req = 1'b0;
        tick(); #1;
        lit("ldr_release_idle", {30'd0, cpu_gnt, ldr_gnt}, 32'd0);
        cpu_req = 1'b1; ldr_req = 1'b1; cpu_write = 1'b0;
        tick(); #1;
        lit("tie3_cpu_gnt", 32'(cpu_gnt), 32'd1);
        lit("tie3_ldr_gnt", 32'(ldr_gnt), 32'd0);
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick(); tick();

        @(negedge clk); @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
